sum_ram_drain: RTL and testbench
================================

# sum_ram_drain

Drain stage directly downstream of the accumulate-into-sum-RAM stage. After accumulation completes, it sweeps the sum RAM read port over a programmed address range and absorbs the RAM read latency. Each signed C_DSIZE-bit partial sum is requantised (rounding arithmetic right shift plus signed saturation) to C_OSIZE bits and presented on a valid/ready stream toward the output buffer writer. Backpressure is handled with credit-based read issue into an 8-entry output FIFO, so no read result is ever dropped.

## Interface
Parameters:
- C_DSIZE, 24, width of sum RAM read data (signed two's complement)
- C_ASIZE, 10, sum RAM address width
- C_OSIZE, 8, output word width (signed)
- C_RD_LAT, 2, sum RAM read latency in cycles from O_raddr to valid I_rdata; legal range 1..4

Ports:
- I_clk  in  1  single clock; all logic rising-edge
- I_rst  in  1  asynchronous, active-high reset
- I_start  in  1  one-cycle start pulse; honoured only in IDLE
- I_depth  in  C_ASIZE  last address to read; sweep covers 0..I_depth, so 0 = one word; sampled on accepted I_start
- I_shift  in  5  right-shift amount 0..C_DSIZE-1; sampled on accepted I_start
- O_rden  out  1  read enable to sum RAM
- O_raddr  out  C_ASIZE  read address to sum RAM
- I_rdata  in  C_DSIZE  sum RAM read data, valid C_RD_LAT cycles after O_rden
- O_dout  out  C_OSIZE  requantised word
- O_dout_valid  out  1  O_dout valid
- I_dout_ready  in  1  consumer accepts O_dout when valid && ready
- O_busy  out  1  sweep in progress
- O_done  out  1  one-cycle pulse after the last word is accepted

## Operation
- States:
  - IDLE: I_start latches I_depth and I_shift, clears the address counter, and moves to RUN.
  - RUN: issues reads. After the read with address == latched depth, moves to FLUSH.
  - FLUSH: waits until the read pipeline, quantiser, and FIFO are empty, then moves to DONE.
  - DONE: asserts O_done for one cycle, then returns to IDLE.
- Read issue in RUN:
  - O_rden=1 when inflight + fifo_count < 8. inflight counts the C_RD_LAT read stages plus the one quantiser stage.
  - The address increments on each issued read.
  - O_raddr holds its last value when O_rden=0.
- Valid tracking: a C_RD_LAT-deep shift register of O_rden marks I_rdata valid.
- Quantiser (one register stage):
  - For I_shift>0, t = I_rdata + 2^(I_shift-1), with the sum computed in C_DSIZE+1 bits. For I_shift=0, t = I_rdata.
  - q = t >>> I_shift (arithmetic shift).
  - Saturate q to [-2^(C_OSIZE-1), 2^(C_OSIZE-1)-1].
- FIFO: 8 entries, first-word-fall-through. Pop on O_dout_valid && I_dout_ready. The credit rule guarantees it never overflows.
- Output ordering: words leave strictly in address order 0..depth.
- I_start outside IDLE is ignored; latched depth and shift do not change.
- Changes to I_depth or I_shift during a sweep have no effect.
- Reset mid-sweep: asynchronously returns to IDLE, clears the FIFO, counters, and valid pipeline, and drops all in-flight data.

## Timing
- Reset values: O_rden=0, O_raddr=0, O_dout=0, O_dout_valid=0, O_busy=0, O_done=0.
- I_start sampled at edge of cycle 0:
  - O_busy=1 from cycle 1.
  - First O_rden=1 (addr 0) in cycle 1.
  - First O_dout_valid in cycle 2+C_RD_LAT.
- With I_dout_ready held 1:
  - Throughput is one word per cycle.
  - O_rden stays high for depth+1 consecutive cycles.
  - The last word is valid in cycle 2+C_RD_LAT+depth.
- O_done is high in the cycle after the last handshake. O_busy falls in that same cycle.
- A new I_start is accepted the cycle after O_done.
- With I_dout_ready=0 indefinitely, exactly 8 reads are issued, then O_rden stays 0 until a pop frees a credit.
- When a pop and a read return happen in the same cycle, the FIFO count is unchanged.

## Configuration
- Macro SUM_RAM_DRAIN_RELU_EN:
  - Defined: after rounding and before saturation, negative q is forced to 0, so O_dout ranges 0..2^(C_OSIZE-1)-1.
  - Undefined: full signed saturation as described above.

## Test plan
- Basic sweep: depth=3, shift=0, RAM holds {5,-3,127,-128}, ready=1. Expected: O_dout {5,-3,127,-128} on consecutive cycles, first valid at cycle 4 (C_RD_LAT=2), O_done at cycle 8.
- Rounding and saturation: shift=4, data {24, -24, 4000, -4000}. Expected: {2, -1, 127, -128} (-24+8=-16, >>>4 gives -1). With RELU_EN, -1 becomes 0 and -128 becomes 0.
- Backpressure: depth=20, ready=0 for the first 30 cycles. Expected: exactly 8 O_rden pulses. After ready rises, all 21 words arrive in order with none lost or duplicated.
- Random ready: depth=1023 with ready toggling at 50% pseudo-random. Expected: output matches the scoreboard, the FIFO never overflows, and O_done pulses exactly once.
- Ignored start: I_start pulsed mid-sweep with a different depth. Expected: no effect and the original depth completes. A start in the cycle after O_done begins a new sweep.
- Reset mid-sweep: assert I_rst at word 10 of 50. Expected: all outputs go to reset values asynchronously. A following start with depth=2 returns only 3 fresh words.

Source files
------------

// File: rtl/sum_ram_drain.sv
`default_nettype none
// ============================================================================
// Module   : sum_ram_drain
// Purpose  : Sweeps the sum RAM read port over addresses 0..depth once
//            accumulation has finished. Each signed partial sum is rounded,
//            arithmetically right-shifted and saturated to C_OSIZE bits, then
//            offered on a valid/ready stream. Reads are issued against credits
//            of an 8-entry first-word-fall-through FIFO, so backpressure never
//            drops a read result.
// Ports    : I_clk, I_rst (async, active-high)
//            I_start, I_depth, I_shift   - sweep command (sampled in IDLE)
//            O_rden, O_raddr, I_rdata    - sum RAM read port
//            O_dout, O_dout_valid, I_dout_ready - output stream
//            O_busy, O_done              - status
// Options  : `define SUM_RAM_DRAIN_RELU_EN clamps negative results to zero
//            before saturation.
// Revision : 1.0 - initial release
// ============================================================================
module sum_ram_drain #(
  parameter int C_DSIZE  = 24,
  parameter int C_ASIZE  = 10,
  parameter int C_OSIZE  = 8,
  parameter int C_RD_LAT = 2
) (
  input  logic               I_clk,
  input  logic               I_rst,
  input  logic               I_start,
  input  logic [C_ASIZE-1:0] I_depth,
  input  logic [4:0]         I_shift,
  output logic               O_rden,
  output logic [C_ASIZE-1:0] O_raddr,
  input  logic [C_DSIZE-1:0] I_rdata,
  output logic [C_OSIZE-1:0] O_dout,
  output logic               O_dout_valid,
  input  logic               I_dout_ready,
  output logic               O_busy,
  output logic               O_done
);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_run   = 2'd1;
  localparam logic [1:0] c_st_flush = 2'd2;
  localparam logic [1:0] c_st_done  = 2'd3;

  localparam logic signed [C_DSIZE:0] c_qmax = (C_DSIZE+1)'((1 << (C_OSIZE-1)) - 1);
  localparam logic signed [C_DSIZE:0] c_qmin = ~c_qmax;

  logic [1:0]         r_state;
  logic [C_ASIZE-1:0] r_addr;
  logic [C_ASIZE-1:0] r_depth;
  logic [4:0]         r_shift;
  logic [C_RD_LAT-1:0] r_vld;
  logic [C_OSIZE-1:0] r_mem [0:7];
  logic [2:0]         r_wptr;
  logic [2:0]         r_rptr;
  logic [3:0]         r_count;

  logic [3:0] w_inflight;
  logic       w_rden;
  logic       w_push;
  logic       w_pop;
  logic [3:0] w_count_nxt;
  logic       w_drained;

  logic signed [C_DSIZE:0] w_ext;
  logic signed [C_DSIZE:0] w_rnd;
  logic signed [C_DSIZE:0] w_t;
  logic signed [C_DSIZE:0] w_q;
  logic signed [C_DSIZE:0] w_qr;
  logic [C_OSIZE-1:0]      w_sat;

  // Reads still travelling through the RAM latency pipe. The FIFO write
  // register doubles as the quantiser register, so once a result leaves this
  // pipe it already occupies a FIFO slot and is covered by r_count.
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < C_RD_LAT; i++) begin
      w_inflight = w_inflight + {3'b000, r_vld[i]};
    end
  end

  assign w_rden       = (r_state == c_st_run) && ((w_inflight + r_count) < 4'd8);
  assign w_push       = r_vld[C_RD_LAT-1];
  assign O_dout_valid = (r_count != 4'd0);
  assign w_pop        = O_dout_valid && I_dout_ready;
  assign w_count_nxt  = r_count + {3'b000, w_push} - {3'b000, w_pop};
  // Leave FLUSH on the edge of the final pop so O_done lands right after it.
  assign w_drained    = (r_vld == '0) && (w_count_nxt == 4'd0);

  // Requantiser: round half up, arithmetic shift, optional ReLU, saturate.
  always_comb begin
    w_ext = {I_rdata[C_DSIZE-1], I_rdata};
    w_rnd = '0;
    if (r_shift != 5'd0) begin
      w_rnd = (C_DSIZE+1)'(1) << (r_shift - 5'd1);
    end
    w_t = w_ext + w_rnd;
    w_q = w_t >>> r_shift;
`ifdef SUM_RAM_DRAIN_RELU_EN
    w_qr = (w_q < 0) ? '0 : w_q;
`else
    w_qr = w_q;
`endif
    if (w_qr > c_qmax) begin
      w_sat = c_qmax[C_OSIZE-1:0];
    end else if (w_qr < c_qmin) begin
      w_sat = c_qmin[C_OSIZE-1:0];
    end else begin
      w_sat = w_qr[C_OSIZE-1:0];
    end
  end

  // Control, read pipe and FIFO bookkeeping.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      r_state <= c_st_idle;
      r_addr  <= '0;
      r_depth <= '0;
      r_shift <= '0;
      r_vld   <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_vld[0] <= w_rden;
      for (int i = 1; i < C_RD_LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
      end
      if (w_push) begin
        r_wptr <= r_wptr + 3'd1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 3'd1;
      end
      r_count <= w_count_nxt;

      case (r_state)
        c_st_idle: begin
          if (I_start) begin
            r_depth <= I_depth;
            r_shift <= I_shift;
            r_addr  <= '0;
            r_state <= c_st_run;
          end
        end
        c_st_run: begin
          if (w_rden) begin
            // Park on the last address rather than running past it.
            if (r_addr == r_depth) begin
              r_state <= c_st_flush;
            end else begin
              r_addr <= r_addr + C_ASIZE'(1);
            end
          end
        end
        c_st_flush: begin
          if (w_drained) begin
            r_state <= c_st_done;
          end
        end
        default: begin
          r_state <= c_st_idle;
        end
      endcase
    end
  end

  // FIFO storage needs no reset; the head is masked while empty.
  always_ff @(posedge I_clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_sat;
    end
  end

  assign O_rden  = w_rden;
  assign O_raddr = r_addr;
  assign O_dout  = O_dout_valid ? r_mem[r_rptr] : '0;
  assign O_busy  = (r_state == c_st_run) || (r_state == c_st_flush);
  assign O_done  = (r_state == c_st_done);

endmodule
`default_nettype wire

// File: tb/tb_sum_ram_drain.sv
`default_nettype none
// ============================================================================
// Module   : tb_sum_ram_drain
// Purpose  : Directed self-checking bench for sum_ram_drain with a 2-cycle
//            RAM model and a handshake monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sum_ram_drain;

  localparam int DW  = 24;
  localparam int AW  = 10;
  localparam int OW  = 8;
  localparam int LAT = 2;

  logic          I_clk = 1'b0;
  logic          I_rst = 1'b1;
  logic          I_start = 1'b0;
  logic [AW-1:0] I_depth = '0;
  logic [4:0]    I_shift = '0;
  logic          I_dout_ready = 1'b0;
  logic [DW-1:0] I_rdata = '0;
  logic          O_rden;
  logic [AW-1:0] O_raddr;
  logic [OW-1:0] O_dout;
  logic          O_dout_valid;
  logic          O_busy;
  logic          O_done;

  sum_ram_drain #(.C_DSIZE(DW), .C_ASIZE(AW), .C_OSIZE(OW), .C_RD_LAT(LAT)) dut (
    .I_clk(I_clk), .I_rst(I_rst), .I_start(I_start), .I_depth(I_depth),
    .I_shift(I_shift), .O_rden(O_rden), .O_raddr(O_raddr), .I_rdata(I_rdata),
    .O_dout(O_dout), .O_dout_valid(O_dout_valid), .I_dout_ready(I_dout_ready),
    .O_busy(O_busy), .O_done(O_done)
  );

  always #5 I_clk = ~I_clk;

  int cyc = 0;
  always @(posedge I_clk) cyc <= cyc + 1;

  // Sum RAM model: data appears LAT cycles after the read enable.
  logic signed [DW-1:0] ram [0:1023];
  logic [DW-1:0] rd_p1 = '0;
  always @(posedge I_clk) begin
    rd_p1   <= O_rden ? ram[O_raddr] : '0;
    I_rdata <= rd_p1;
  end

  // Random ready only in mode 2; otherwise the main block drives it.
  int ready_mode = 0;
  always @(posedge I_clk) begin
    #1;
    if (ready_mode == 2) I_dout_ready = 1'($urandom_range(0, 1));
  end

  // Monitor
  int   got_q[$];
  int   got_cyc[$];
  int   rden_cnt = 0;
  int   done_cnt = 0;
  int   done_cyc = -1;
  int   max_out = 0;
  logic done_busy = 1'b0;
  int   start_cyc = 0;

  always @(negedge I_clk) begin
    if (!I_rst) begin
      if (O_dout_valid && I_dout_ready) begin
        got_q.push_back(int'($signed(O_dout)));
        got_cyc.push_back(cyc - start_cyc);
      end
      if (O_rden) rden_cnt = rden_cnt + 1;
      if (O_done) begin
        done_cnt  = done_cnt + 1;
        done_cyc  = cyc - start_cyc;
        done_busy = O_busy;
      end
      if (rden_cnt - got_q.size() > max_out) max_out = rden_cnt - got_q.size();
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge I_clk);
    #1;
  endtask

  function automatic int got_at(input int i);
    if (i < got_q.size()) return got_q[i];
    return -99999;
  endfunction

  function automatic int model_q(input int d, input int sh);
    longint t;
    t = d;
    if (sh > 0) t = t + (longint'(1) << (sh - 1));
    t = t >>> sh;
`ifdef SUM_RAM_DRAIN_RELU_EN
    if (t < 0) t = 0;
`endif
    if (t > 127) t = 127;
    if (t < -128) t = -128;
    return int'(t);
  endfunction

  task automatic do_start(input int d, input int sh);
    I_start = 1'b1;
    I_depth = AW'(d);
    I_shift = 5'(sh);
    start_cyc = cyc;
    got_q.delete();
    got_cyc.delete();
    rden_cnt = 0;
    done_cnt = 0;
    done_cyc = -1;
    max_out  = 0;
    tick();
    I_start = 1'b0;
  endtask

  // Returns in the cycle after O_done.
  task automatic wait_done(input int budget, input string tag);
    int n;
    n = 0;
    while (!O_done && n < budget) begin
      tick();
      n++;
    end
    if (!O_done) chk(tag, 0, 1);
    tick();
  endtask

  task automatic check_words(input string tag, input int d, input int sh);
    int nbad;
    nbad = 0;
    chk({tag, "_count"}, got_q.size(), d + 1);
    for (int i = 0; i <= d; i++) begin
      if (got_at(i) != model_q(int'(ram[i]), sh)) nbad++;
    end
    chk({tag, "_bad_words"}, nbad, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_rden", int'(O_rden), 0);
    chk("rst_raddr", int'(O_raddr), 0);
    chk("rst_dout", int'(O_dout), 0);
    chk("rst_valid", int'(O_dout_valid), 0);
    chk("rst_busy", int'(O_busy), 0);
    chk("rst_done", int'(O_done), 0);
    I_rst = 1'b0;
    I_dout_ready = 1'b1;
    tick();

    // Basic sweep
    ram[0] = 24'sd5; ram[1] = -24'sd3; ram[2] = 24'sd127; ram[3] = -24'sd128;
    do_start(3, 0);
    chk("basic_busy_c1", int'(O_busy), 1);
    chk("basic_rden_c1", int'(O_rden), 1);
    chk("basic_raddr_c1", int'(O_raddr), 0);
    wait_done(50, "basic_timeout");
    chk("basic_count", got_q.size(), 4);
    chk("basic_w0", got_at(0), 5);
`ifdef SUM_RAM_DRAIN_RELU_EN
    chk("basic_w1", got_at(1), 0);
    chk("basic_w2", got_at(2), 127);
    chk("basic_w3", got_at(3), 0);
`else
    chk("basic_w1", got_at(1), -3);
    chk("basic_w2", got_at(2), 127);
    chk("basic_w3", got_at(3), -128);
`endif
    chk("basic_first_cyc", (got_cyc.size() > 0) ? got_cyc[0] : -1, 4);
    chk("basic_last_cyc", (got_cyc.size() > 3) ? got_cyc[3] : -1, 7);
    chk("basic_done_cyc", done_cyc, 8);
    chk("basic_busy_at_done", int'(done_busy), 0);
    chk("basic_rden_cnt", rden_cnt, 4);

    // Rounding and saturation
    ram[0] = 24'sd24; ram[1] = -24'sd24; ram[2] = 24'sd4000; ram[3] = -24'sd4000;
    do_start(3, 4);
    wait_done(50, "round_timeout");
    chk("round_count", got_q.size(), 4);
    chk("round_w0", got_at(0), 2);
`ifdef SUM_RAM_DRAIN_RELU_EN
    chk("round_w1", got_at(1), 0);
    chk("round_w2", got_at(2), 127);
    chk("round_w3", got_at(3), 0);
`else
    chk("round_w1", got_at(1), -1);
    chk("round_w2", got_at(2), 127);
    chk("round_w3", got_at(3), -128);
`endif

    // Backpressure
    for (int i = 0; i <= 20; i++) ram[i] = DW'(i * 5 - 40);
    I_dout_ready = 1'b0;
    do_start(20, 0);
    repeat (29) tick();
    chk("bp_rden_cnt", rden_cnt, 8);
    chk("bp_none_out", got_q.size(), 0);
    I_dout_ready = 1'b1;
    wait_done(100, "bp_timeout");
    check_words("bp", 20, 0);
    chk("bp_max_outstanding_ok", int'(max_out <= 8), 1);

    // Random ready over a full-range sweep
    for (int i = 0; i < 1024; i++) ram[i] = DW'($urandom);
    ready_mode = 2;
    do_start(1023, 16);
    wait_done(6000, "rand_timeout");
    ready_mode = 0;
    tick();
    I_dout_ready = 1'b1;
    check_words("rand", 1023, 16);
    chk("rand_done_once", done_cnt, 1);
    chk("rand_max_outstanding_ok", int'(max_out <= 8), 1);

    // Ignored start mid-sweep, then restart right after O_done
    for (int i = 0; i <= 15; i++) ram[i] = DW'(i * 3 - 20);
    do_start(15, 0);
    repeat (4) tick();
    I_start = 1'b1; I_depth = AW'(3); I_shift = 5'd2;
    tick();
    I_start = 1'b0;
    wait_done(100, "ign_timeout");
    check_words("ign", 15, 0);
    chk("ign_rden_cnt", rden_cnt, 16);
    do_start(2, 1);
    chk("restart_busy_c1", int'(O_busy), 1);
    wait_done(50, "restart_timeout");
    check_words("restart", 2, 1);

    // Reset mid-sweep
    for (int i = 0; i <= 49; i++) ram[i] = DW'(i);
    do_start(49, 0);
    begin
      int n;
      n = 0;
      while (got_q.size() < 10 && n < 100) begin
        tick();
        n++;
      end
      chk("rst_mid_reached", int'(got_q.size() >= 10), 1);
    end
    #2;
    I_rst = 1'b1;
    #1;
    chk("arst_rden", int'(O_rden), 0);
    chk("arst_raddr", int'(O_raddr), 0);
    chk("arst_dout", int'(O_dout), 0);
    chk("arst_valid", int'(O_dout_valid), 0);
    chk("arst_busy", int'(O_busy), 0);
    chk("arst_done", int'(O_done), 0);
    tick(); tick();
    I_rst = 1'b0;
    tick();
    ram[0] = 24'sd100; ram[1] = -24'sd100; ram[2] = 24'sd55;
    do_start(2, 0);
    wait_done(50, "post_rst_timeout");
    check_words("post_rst", 2, 0);
    repeat (5) tick();
    chk("post_rst_no_extra", got_q.size(), 3);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
